// File: rtl/snoop_memoria_responde.sv
// ---------------------------------------------------------------------------
// snoop_memoria_responde
//   Memory-side responder for the snooping coherence bus. It accepts
//   coherence messages from a cache controller and owns the backing block
//   memory (2**ADDR_W entries of DATA_W bits).
//     WRITE_MISS 2'b00 / READ_MISS 2'b01 : collect snoop acks, then answer
//         with block data from memory, or from the exclusive holder if it
//         aborts the memory access and supplies its block.
//     INVALIDATE 2'b10 : collect snoop acks, then answer with data 0.
//     WRITE_BACK 2'b11 : write memory on the accept edge, no response.
//
//   Ports
//     clk, rst_n              clock, synchronous active-low reset
//     req_valid/req_ready     bus message handshake
//     req_msg/addr/src/data   message code, block address, requester id, data
//     snoop_ack               per-cache snoop-complete pulses
//     snoop_abort             exclusive holder aborts the memory access
//     snoop_wb_valid/data     aborting cache presents its block
//     resp_valid/resp_ready   response handshake towards the requester
//     resp_dst/data           destination id and block data
//     resp_from_cache         data came from a cache rather than memory
//     busy                    transaction in flight
//     err_timeout             sticky snoop timeout flag
//
//   Optional feature macro: SNOOP_TIMEOUT_EN
//     Defined   : SNOOP/WAIT_WB give up after SNOOP_TIMEOUT cycles, set
//                 err_timeout and fall back to a memory (or zero) response.
//     Undefined : waits indefinitely, err_timeout is tied to 0.
// ---------------------------------------------------------------------------
module snoop_memoria_responde #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 8,
  parameter int NUM_CACHES    = 3,
  parameter int SNOOP_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_msg,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [1:0]            req_src,
  input  logic [DATA_W-1:0]     req_data,
  input  logic [NUM_CACHES-1:0] snoop_ack,
  input  logic                  snoop_abort,
  input  logic                  snoop_wb_valid,
  input  logic [DATA_W-1:0]     snoop_wb_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_dst,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_from_cache,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam logic [1:0] MSG_INV = 2'b10;
  localparam logic [1:0] MSG_WB  = 2'b11;

  typedef enum logic [2:0] {IDLE, SNOOP, WAIT_WB, MEM_RD, RESP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              msg_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [1:0]              src_q;
  logic [NUM_CACHES-1:0]   ack_q;
  logic [DATA_W-1:0]       resp_data_q;
  logic                    resp_from_cache_q;
  logic [DATA_W-1:0]       mem_q [2**ADDR_W];

  logic                    accept;
  logic                    is_wb;
  logic [NUM_CACHES-1:0]   ack_all;
  logic [NUM_CACHES-1:0]   ack_mask;
  logic                    acks_done;
  logic                    abort_take;
  logic                    wb_capture;
  logic                    timeout_hit;

  assign accept     = req_valid && req_ready;
  assign is_wb      = (req_msg == MSG_WB);
  assign ack_all    = ack_q | snoop_ack;
  // Every listening cache except the requester must acknowledge.
  assign ack_mask   = ~(NUM_CACHES'(1) << src_q);
  assign acks_done  = ((ack_all & ack_mask) == ack_mask);
  // An abort only matters for misses; invalidates carry no data.
  assign abort_take = snoop_abort && (msg_q != MSG_INV);

`ifdef SNOOP_TIMEOUT_EN
  localparam int CNT_W = $clog2(SNOOP_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             to_fire;

  assign timeout_hit = ((state_q == SNOOP) || (state_q == WAIT_WB)) &&
                       (cnt_q == CNT_W'(SNOOP_TIMEOUT - 1));
  // The flag is raised only when the timeout actually decides the exit.
  assign to_fire = timeout_hit &&
                   (((state_q == SNOOP) && !abort_take && !acks_done) ||
                    ((state_q == WAIT_WB) && !snoop_wb_valid));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept)
        cnt_q <= '0;
      else if ((state_q == SNOOP) || (state_q == WAIT_WB))
        cnt_q <= cnt_q + 1'b1;
      if (to_fire)
        err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register plus datapath and memory updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      msg_q             <= '0;
      addr_q            <= '0;
      src_q             <= '0;
      ack_q             <= '0;
      resp_data_q       <= '0;
      resp_from_cache_q <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++)
        mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        msg_q  <= req_msg;
        addr_q <= req_addr;
        src_q  <= req_src;
        ack_q  <= '0;
        if (is_wb)
          mem_q[req_addr] <= req_data;
      end
      if (state_q == SNOOP)
        ack_q <= ack_all;
      if (wb_capture) begin
        mem_q[addr_q]     <= snoop_wb_data;
        resp_data_q       <= snoop_wb_data;
        resp_from_cache_q <= 1'b1;
      end
      // SNOOP straight to RESP without a capture is the invalidate answer.
      if ((state_q == SNOOP) && (state_d == RESP) && !wb_capture) begin
        resp_data_q       <= '0;
        resp_from_cache_q <= 1'b0;
      end
      if (state_q == MEM_RD) begin
        resp_data_q       <= mem_q[addr_q];
        resp_from_cache_q <= 1'b0;
      end
    end
  end

  // Next-state logic; abort beats ack completion, completion beats timeout.
  always_comb begin
    state_d    = state_q;
    wb_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !is_wb)
          state_d = SNOOP;
      end
      SNOOP: begin
        if (abort_take) begin
          if (snoop_wb_valid) begin
            state_d    = RESP;
            wb_capture = 1'b1;
          end else begin
            state_d = WAIT_WB;
          end
        end else if (acks_done || timeout_hit) begin
          state_d = (msg_q == MSG_INV) ? RESP : MEM_RD;
        end
      end
      WAIT_WB: begin
        if (snoop_wb_valid) begin
          state_d    = RESP;
          wb_capture = 1'b1;
        end else if (timeout_hit) begin
          state_d = MEM_RD;
        end
      end
      MEM_RD:  state_d = RESP;
      RESP: begin
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

  assign resp_dst        = src_q;
  assign resp_data       = resp_data_q;
  assign resp_from_cache = resp_from_cache_q;

endmodule

// File: tb/tb_snoop_memoria_responde.sv
// ---------------------------------------------------------------------------
// tb_snoop_memoria_responde
//   Self-checking bench: a table of directed transactions, hand-written
//   corner sequences, and a randomized phase scored against a behavioural
//   memory model derived from the message rules.
// ---------------------------------------------------------------------------
module tb_snoop_memoria_responde;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_msg = 2'b00;
  logic [3:0] req_addr = 4'd0;
  logic [1:0] req_src = 2'd0;
  logic [7:0] req_data = 8'd0;
  logic [2:0] snoop_ack = 3'b000;
  logic       snoop_abort = 1'b0;
  logic       snoop_wb_valid = 1'b0;
  logic [7:0] snoop_wb_data = 8'd0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [1:0] resp_dst;
  logic [7:0] resp_data;
  logic       resp_from_cache;
  logic       busy;
  logic       err_timeout;

  int testsRun = 0;
  int testsFailed = 0;
  logic [7:0] modelMem [16];

  localparam logic [1:0] WM = 2'b00, RM = 2'b01, INV = 2'b10, WB = 2'b11;

  typedef struct {
    string      name;
    logic [1:0] msg;
    logic [3:0] addr;
    logic [1:0] src;
    int         mode;
    logic [7:0] wbData;
    int         hold;
    int         expLat;
    logic [7:0] expData;
    logic       expFc;
  } vec_t;

  vec_t vecs [8];

  snoop_memoria_responde #(.ADDR_W(4), .DATA_W(8), .NUM_CACHES(3), .SNOOP_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_msg(req_msg), .req_addr(req_addr), .req_src(req_src), .req_data(req_data),
    .snoop_ack(snoop_ack), .snoop_abort(snoop_abort), .snoop_wb_valid(snoop_wb_valid),
    .snoop_wb_data(snoop_wb_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_dst(resp_dst), .resp_data(resp_data), .resp_from_cache(resp_from_cache),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) modelMem[i] = 8'h00;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " req_ready"}, int'(req_ready), 1);
    checkOutput({tag, " resp_valid"}, int'(resp_valid), 0);
    checkOutput({tag, " resp_dst"}, int'(resp_dst), 0);
    checkOutput({tag, " resp_data"}, int'(resp_data), 0);
    checkOutput({tag, " resp_from_cache"}, int'(resp_from_cache), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " err_timeout"}, int'(err_timeout), 0);
  endtask

  task automatic writeBack(input logic [3:0] addr, input logic [7:0] data);
    req_valid = 1'b1; req_msg = WB; req_addr = addr; req_data = data;
    tick();
    req_valid = 1'b0;
    modelMem[addr] = data;
  endtask

  function automatic logic [2:0] ackMask(input logic [1:0] src);
    logic [2:0] m;
    m = 3'b111;
    if (src < 2'd3) m[src] = 1'b0;
    return m;
  endfunction

  // mode 0: all required acks at edge T+1+ackDelay
  // mode 1: abort + write-back data at T+1
  // mode 2: abort at T+1, write-back data at T+2
  // mode 3: no snoop activity at all
  task automatic applyStimulus(input string name, input logic [1:0] msg, input logic [3:0] addr,
                               input logic [1:0] src, input int mode, input int ackDelay,
                               input logic [7:0] wbData, input int hold, input int expLat,
                               input logic [7:0] expData, input logic expFc);
    bit seen;
    int n;
    seen = 0; n = 0;
    req_valid = 1'b1; req_msg = msg; req_addr = addr; req_src = src;
    tick();
    req_valid = 1'b0;
    checkOutput({name, " busy"}, int'(busy), 1);
    for (int j = 1; j <= 40 && !seen; j++) begin
      snoop_ack = 3'b000; snoop_abort = 1'b0; snoop_wb_valid = 1'b0;
      if (mode == 0 && j == 1 + ackDelay) snoop_ack = ackMask(src);
      if (mode == 1 && j == 1) begin snoop_abort = 1'b1; snoop_wb_valid = 1'b1; snoop_wb_data = wbData; end
      if (mode == 2 && j == 1) snoop_abort = 1'b1;
      if (mode == 2 && j == 2) begin snoop_wb_valid = 1'b1; snoop_wb_data = wbData; end
      tick();
      snoop_ack = 3'b000; snoop_abort = 1'b0; snoop_wb_valid = 1'b0;
      if (resp_valid) begin seen = 1; n = j; end
    end
    checkOutput({name, " latency"}, seen ? n + 1 : -1, expLat);
    if (seen) begin
      checkOutput({name, " resp_data"}, int'(resp_data), int'(expData));
      checkOutput({name, " resp_dst"}, int'(resp_dst), int'(src));
      checkOutput({name, " resp_from_cache"}, int'(resp_from_cache), int'(expFc));
      for (int h = 0; h < hold; h++) begin
        tick();
        checkOutput({name, " held resp_valid"}, int'(resp_valid), 1);
        checkOutput({name, " held resp_data"}, int'(resp_data), int'(expData));
        checkOutput({name, " held req_ready"}, int'(req_ready), 0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      checkOutput({name, " idle after resp"}, int'(busy), 0);
    end
  endtask

  initial begin
    vecs[0] = '{"rm_cleared",  RM,  4'd5,  2'd1, 0, 8'h00, 0, 3, 8'h00, 1'b0};
    vecs[1] = '{"rm_a5",       RM,  4'd3,  2'd0, 0, 8'h00, 0, 3, 8'hA5, 1'b0};
    vecs[2] = '{"wm_c2c",      WM,  4'd7,  2'd1, 1, 8'h3C, 0, 2, 8'h3C, 1'b1};
    vecs[3] = '{"rm_after_c2c",RM,  4'd7,  2'd2, 0, 8'h00, 0, 3, 8'h3C, 1'b0};
    vecs[4] = '{"inv",         INV, 4'd2,  2'd2, 0, 8'h00, 0, 2, 8'h00, 1'b0};
    vecs[5] = '{"rm_wait_wb",  RM,  4'd9,  2'd0, 2, 8'h5A, 0, 3, 8'h5A, 1'b1};
    vecs[6] = '{"wm_after_wb", WM,  4'd9,  2'd1, 0, 8'h00, 5, 3, 8'h5A, 1'b0};
    vecs[7] = '{"rm_pipe_wb",  RM,  4'd12, 2'd1, 0, 8'h00, 0, 3, 8'h77, 1'b0};

    // Reset with a nonzero memory entry, which the reset must clear.
    doReset();
    checkResetOutputs("reset0");
    writeBack(4'd5, 8'hFF);
    doReset();
    checkResetOutputs("reset1");

    // Back-to-back write-backs, one per cycle.
    req_valid = 1'b1; req_msg = WB; req_addr = 4'd3; req_data = 8'hA5;
    tick();
    checkOutput("wb pipelined req_ready", int'(req_ready), 1);
    req_addr = 4'd12; req_data = 8'h77;
    tick();
    req_valid = 1'b0;
    checkOutput("wb no busy", int'(busy), 0);

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].name, vecs[i].msg, vecs[i].addr, vecs[i].src, vecs[i].mode, 0,
                    vecs[i].wbData, vecs[i].hold, vecs[i].expLat, vecs[i].expData, vecs[i].expFc);

    // Invalidate with acks spread over two cycles and an ignored abort.
    req_valid = 1'b1; req_msg = INV; req_addr = 4'd0; req_src = 2'd2;
    tick();
    req_valid = 1'b0;
    snoop_ack = 3'b001; snoop_abort = 1'b1;
    tick();
    snoop_ack = 3'b010; snoop_abort = 1'b0;
    checkOutput("inv split first ack", int'(resp_valid), 0);
    tick();
    snoop_ack = 3'b000;
    checkOutput("inv split resp_valid", int'(resp_valid), 1);
    checkOutput("inv split resp_data", int'(resp_data), 0);
    checkOutput("inv split resp_dst", int'(resp_dst), 2);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset during SNOOP drops the transaction.
    req_valid = 1'b1; req_msg = RM; req_addr = 4'd3; req_src = 2'd0;
    tick();
    req_valid = 1'b0;
    checkOutput("mid reset in snoop", int'(busy), 1);
    rst_n = 1'b0;
    snoop_ack = 3'b110;
    tick();
    rst_n = 1'b1;
    snoop_ack = 3'b000;
    for (int i = 0; i < 16; i++) modelMem[i] = 8'h00;
    checkResetOutputs("mid reset");
    tick(); tick();
    checkOutput("mid reset no resp", int'(resp_valid), 0);
    applyStimulus("rm_after_reset", RM, 4'd3, 2'd0, 0, 0, 8'h00, 0, 3, 8'h00, 1'b0);

`ifdef SNOOP_TIMEOUT_EN
    applyStimulus("timeout_rm", RM, 4'd7, 2'd1, 3, 0, 8'h00, 0, 10, 8'h00, 1'b0);
    checkOutput("timeout flag set", int'(err_timeout), 1);
    applyStimulus("after_timeout", RM, 4'd7, 2'd1, 0, 0, 8'h00, 0, 3, 8'h00, 1'b0);
    checkOutput("timeout flag sticky", int'(err_timeout), 1);
    doReset();
    checkOutput("timeout flag cleared", int'(err_timeout), 0);
`endif

    // Randomized traffic against the memory model.
    doReset();
    for (int it = 0; it < 60; it++) begin
      logic [1:0] msg;
      logic [3:0] addr;
      logic [1:0] src;
      logic [7:0] d;
      int mode, dly, lat;
      logic [7:0] expD;
      logic expFc;
      addr = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        writeBack(addr, d);
      end else begin
        msg = 2'($urandom_range(0, 2));
        src = 2'($urandom_range(0, 2));
        mode = (msg == INV) ? 0 : $urandom_range(0, 2);
        dly = (mode == 0) ? $urandom_range(0, 2) : 0;
        if (mode == 0) begin
          lat = ((msg == INV) ? 2 : 3) + dly;
          expD = (msg == INV) ? 8'h00 : modelMem[addr];
          expFc = 1'b0;
        end else begin
          lat = (mode == 1) ? 2 : 3;
          expD = d;
          expFc = 1'b1;
          modelMem[addr] = d;
        end
        applyStimulus("random", msg, addr, src, mode, dly, d, $urandom_range(0, 2), lat, expD, expFc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/snoop_memoria_responde.md
Name: snoop_memoria_responde

Overview:
Memory-side responder for the snooping coherence bus. It accepts coherence messages placed on the bus by a cache controller: WRITE_MISS 2'b00, READ_MISS 2'b01, INVALIDATE 2'b10, WRITE_BACK 2'b11.
- For misses and invalidates, it collects acknowledgements from the listening caches.
- If a cache holding the block exclusively aborts the memory access, it absorbs that cache's write-back.
- It then returns block data, from memory or from that cache, to the requesting cache.
- It owns the backing block memory of 2**ADDR_W entries.

Parameters:
ADDR_W, 4, block address width (2**ADDR_W memory entries)
DATA_W, 8, block data width
NUM_CACHES, 3, number of caches on the bus (ids 0..NUM_CACHES-1)
SNOOP_TIMEOUT, 8, max cycles spent in SNOOP (used only with SNOOP_TIMEOUT_EN)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  bus message present
req_ready  out  1  responder can accept a message
req_msg  in  2  message code (00/01/10/11 as above)
req_addr  in  ADDR_W  block address
req_src  in  2  id of requesting cache
req_data  in  DATA_W  block data (WRITE_BACK only)
snoop_ack  in  NUM_CACHES  per-cache snoop-complete pulse
snoop_abort  in  1  exclusive holder aborts memory access (rfo)
snoop_wb_valid  in  1  aborting cache presents its block
snoop_wb_data  in  DATA_W  aborting cache's block data
resp_valid  out  1  response to requester valid
resp_ready  in  1  requester accepts response
resp_dst  out  2  destination cache id (= captured req_src)
resp_data  out  DATA_W  block data (0 for INVALIDATE)
resp_from_cache  out  1  data was supplied by a cache, not memory
busy  out  1  transaction in flight (state != IDLE)
err_timeout  out  1  sticky snoop timeout flag

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - All memory entries are cleared to 0.
  - Outputs: req_ready=1, resp_valid=0, resp_dst=0, resp_data=0, resp_from_cache=0, busy=0, err_timeout=0.
  - A reset mid-transaction drops the transaction: no response and no pending memory write.
- States: IDLE, SNOOP, WAIT_WB, MEM_RD, RESP.
- IDLE:
  - req_ready=1.
  - A message is accepted when req_valid & req_ready. At acceptance, msg/addr/src/data are captured.
  - WRITE_BACK: mem[addr]<=req_data on the accept edge; stay in IDLE; no response; fully pipelined, one message per cycle.
  - Any other message goes to SNOOP and clears the ack accumulator.
- SNOOP:
  - ack_acc |= snoop_ack each cycle.
  - The required mask is all caches except req_src.
  - If snoop_abort=1 and the message is READ_MISS or WRITE_MISS:
    - with snoop_wb_valid in the same cycle, go directly to the capture action described under WAIT_WB (then RESP);
    - otherwise go to WAIT_WB.
  - Abort has priority over ack completion when both occur in the same cycle.
  - An abort during INVALIDATE is ignored.
  - Else, once (ack_acc|snoop_ack) covers the mask: INVALIDATE goes to RESP with data 0; READ_MISS and WRITE_MISS go to MEM_RD.
- WAIT_WB:
  - Wait for snoop_wb_valid.
  - On it: mem[addr]<=snoop_wb_data, resp_data<=snoop_wb_data, resp_from_cache<=1, go to RESP.
- MEM_RD: resp_data<=mem[addr], resp_from_cache<=0, go to RESP.
- RESP:
  - resp_valid=1, resp_dst=src.
  - resp_data and resp_dst are held stable until resp_ready.
  - On resp_valid & resp_ready, return to IDLE the next cycle.
- req_ready=0 in every state except IDLE. Messages are never dropped; the bus holds them.
- Latency, accept edge T, all acks at T+1:
  - read/write miss: resp_valid at T+3;
  - invalidate: resp_valid at T+2;
  - cache-to-cache (abort and wb at T+1): resp_valid at T+2.
- Address wrap: req_addr is used modulo 2**ADDR_W. No out-of-range case exists.

Optional Feature:
SNOOP_TIMEOUT_EN.
- Defined:
  - a counter runs in SNOOP and WAIT_WB;
  - after SNOOP_TIMEOUT cycles without completion, set err_timeout (sticky until reset);
  - SNOOP then proceeds as if all acks arrived (MEM_RD, or RESP for INVALIDATE);
  - WAIT_WB proceeds to MEM_RD.
- Undefined: waits indefinitely; err_timeout tied to 0.

Test Plan:
- Reset with mem nonzero -> all outputs at reset values; READ_MISS addr 5 returns resp_data 0.
- WRITE_BACK addr 3 data 8'hA5, then READ_MISS addr 3 src 0, acks 3'b110 at T+1 -> resp_valid at T+3, resp_dst 0, resp_data A5, resp_from_cache 0.
- WRITE_MISS addr 7 src 1; snoop_abort and snoop_wb_valid data 8'h3C at T+1 -> resp_valid at T+2 with data 3C, resp_from_cache 1; later READ_MISS addr 7 returns 3C from memory.
- INVALIDATE src 2; acks arrive one per cycle (bit0, then bit1) -> resp_valid one cycle after the last ack, resp_data 0; abort asserted during it is ignored.
- Response backpressure: resp_ready low for 5 cycles -> resp_valid and resp_data stable, req_ready 0; reset asserted mid-SNOOP -> no response, IDLE next cycle.
- SNOOP_TIMEOUT_EN, SNOOP_TIMEOUT=8, no acks -> err_timeout set after 8 SNOOP cycles, memory response delivered, flag stays 1 until reset.
